spi_chain_sched: RTL
====================

# spi_chain_sched

Frame sequencer for the SPI daisy chain. It holds one transmit byte per chained device, runs a single chip-select frame of NUM_DEV*DW bits (SPI mode 0, MSB first), and stores the bytes clocked back on MISO into a per-device receive buffer. It sits between the system-side enable/result logic and the chain's sclk/cs_n/mosi/miso pins, and replaces free-running tx_enable with an explicit start/busy/done handshake.

## Interface
- NUM_DEV, 3, number of devices in the chain (≥1)
- DW, 8, bits per device word
- CLK_DIV, 4, clk cycles per sclk half-period (≥1)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  frame request; sampled only when busy=0
- busy  out  1  high from the cycle after an accepted start until the done cycle (exclusive)
- done  out  1  one-cycle pulse at frame end; rx buffer valid from this cycle
- wr_en  in  1  write tx buffer entry
- wr_idx  in  $clog2(NUM_DEV)  tx entry index
- wr_data  in  DW  tx byte
- rd_idx  in  $clog2(NUM_DEV)  rx entry index
- rd_data  out  DW  rx entry, combinational from rd_idx
- sclk  out  1  SPI clock, idle low
- cs_n  out  1  chain select, idle high
- mosi  out  1  serial out
- miso  in  1  serial in (synchronous to clk at the bench level)

## Operation
- States: IDLE, SHIFT, HOLD, DONE.
- IDLE: cs_n=1, sclk=0, busy=0. start=1 → load shift register with {tx[NUM_DEV-1],…,tx[0]}, go to SHIFT.
- SHIFT: per bit, CLK_DIV cycles sclk=0 (mosi = current MSB), then CLK_DIV cycles sclk=1. miso is sampled into the rx shift register on the clk edge where sclk goes 0→1. mosi shifts to the next bit on the edge where sclk goes 1→0. After bit NUM_DEV*DW-1 high phase → HOLD.
- HOLD: CLK_DIV cycles, sclk=0, cs_n=0 → DONE.
- DONE: one cycle, cs_n=1, done=1, rx buffer ← rx shift register, → IDLE.
- Rx packing mirrors tx: first received bit → rx[NUM_DEV-1][DW-1]. The last received bit → rx[0][0].
- wr_en while busy=1 is ignored (tx locked). wr_idx ≥ NUM_DEV is ignored. A write in the same cycle as an accepted start is ignored.
- rd_idx ≥ NUM_DEV returns 0. rd_data changes only in the DONE cycle.
- start while busy=1 is ignored and is not queued. start held high re-triggers on the first IDLE cycle after DONE.

## Timing
- Reset (any time, including mid-frame): cs_n=1, sclk=0, mosi=0, busy=0, done=0, state=IDLE, tx/rx buffers=0, counters=0. There is no partial rx update.
- start accepted at edge N → edge N+1: busy=1, cs_n=0, mosi=tx[NUM_DEV-1][DW-1].
- cs_n low for (2*NUM_DEV*DW + 1)*CLK_DIV cycles. Defaults: 196.
- done occurs at (2*NUM_DEV*DW+1)*CLK_DIV + 1 cycles after the accepting edge. busy=0 in the done cycle.
- Minimum start-to-start period is the frame length + 1 cycle. Back-to-back start goes IDLE→SHIFT on the cycle after DONE.
- Counters: half-period counter 0…CLK_DIV-1. Bit counter 0…NUM_DEV*DW-1, width $clog2(NUM_DEV*DW+1). Both wrap to 0 on state exit.

## Structure
- Package spi_chain_pkg holds:
  - the state enum (IDLE, SHIFT, HOLD, DONE);
  - the default DW constant;
  - a function for total frame bits.
- Sub-module spi_sclk_gen: half-period counter. It emits rise_tick, fall_tick and hold_done, enabled by the FSM.
- Tx/rx buffers are register arrays inside the top. There is no memory macro.

## Test plan
- Loopback (miso=mosi), tx = 8'hA5, 8'h3C, 8'hF0 at idx 0, 1, 2, one start → cs_n low exactly 196 cycles. rx idx 0/1/2 = A5/3C/F0. done occurs exactly once.
- miso tied 1 then tied 0, with tx all 8'h00 → rx all 8'hFF, then all 8'h00. mosi stays 0 throughout the frame.
- Write wr_idx=1, wr_data=8'h77 while busy, then rd after done → tx[1] unchanged; second frame echoes the old value. A second start mid-frame gives no extra done and no cs_n glitch.
- Assert rst low at cycle 50 of a frame → cs_n=1 and sclk=0 the same cycle. rd_data=0 for all indices. The next start gives a normal 196-cycle frame.
- CLK_DIV=1, NUM_DEV=1, loopback tx 8'h81 → cs_n low 17 cycles. sclk toggles every cycle. rx[0]=8'h81.
- start held high continuously → successive frames with exactly 1 IDLE cycle between DONE and the next cs_n fall.

Source files
------------

// File: rtl/spi_chain_pkg.sv
// Shared types and constants for the SPI daisy-chain frame sequencer.
package spi_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_DW = 8;

    function automatic int frame_bits(input int num_dev, input int dw);
        return num_dev * dw;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timing for the chain clock: ticks for the sclk rising/falling
// edges while shifting, and for the end of the trailing chip-select hold.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_en,
    input  logic hold_en,
    output logic sclk_phase,
    output logic rise_tick,
    output logic fall_tick,
    output logic hold_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             phase_reg;
    logic             cnt_last;

    assign cnt_last = (cnt_reg == CNT_LAST);

    // Counter and phase fall back to zero whenever the FSM leaves SHIFT/HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (shift_en) begin
            cnt_reg <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
            if (cnt_last) begin
                phase_reg <= ~phase_reg;
            end
        end else if (hold_en) begin
            cnt_reg   <= cnt_last ? '0 : cnt_reg + CNT_W'(1);
            phase_reg <= 1'b0;
        end else begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end
    end

    assign sclk_phase = phase_reg;
    assign rise_tick  = shift_en & ~phase_reg & cnt_last;
    assign fall_tick  = shift_en &  phase_reg & cnt_last;
    assign hold_done  = hold_en & cnt_last;

endmodule

// File: rtl/spi_chain_sched.sv
// Single-frame sequencer for an SPI daisy chain: per-device tx/rx byte buffers,
// start/busy/done handshake, mode-0 MSB-first shifting of NUM_DEV*DW bits.
module spi_chain_sched
    import spi_chain_pkg::*;
#(
    parameter int  NUM_DEV = 3,
    parameter int  DW      = DEF_DW,
    parameter int  CLK_DIV = 4,
    localparam int IDX_W   = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DW-1:0]    wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int TOTAL = frame_bits(NUM_DEV, DW);
    localparam int BIT_W = $clog2(TOTAL + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);

    state_e           state_reg;
    state_e           state_next;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [TOTAL-1:0] tx_shift_reg;
    logic [TOTAL-1:0] rx_shift_reg;
    logic [DW-1:0]    tx_mem_reg [NUM_DEV];
    logic [DW-1:0]    rx_mem_reg [NUM_DEV];

    logic [TOTAL-1:0] tx_flat;
    logic [DW-1:0]    rx_unpacked [NUM_DEV];
    logic             sclk_phase;
    logic             rise_tick;
    logic             fall_tick;
    logic             hold_done;
    logic             wr_accept;

    // Device NUM_DEV-1 occupies the MSBs so its word leaves first and is the
    // first word to arrive back.
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_pack
        assign tx_flat[gi*DW +: DW] = tx_mem_reg[gi];
        assign rx_unpacked[gi]      = rx_shift_reg[gi*DW +: DW];
    end

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (state_reg == SHIFT),
        .hold_en    (state_reg == HOLD),
        .sclk_phase (sclk_phase),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .hold_done  (hold_done)
    );

    // The tx buffer is locked from the accepting cycle until the frame ends.
    assign wr_accept = wr_en && (state_reg == IDLE) && !start && (int'(wr_idx) < NUM_DEV);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (fall_tick && (bit_cnt_reg == BIT_LAST)) state_next = HOLD;
            HOLD:    if (hold_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            for (int i = 0; i < NUM_DEV; i++) begin
                tx_mem_reg[i] <= '0;
                rx_mem_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < NUM_DEV; i++) begin
                if (wr_accept && (wr_idx == IDX_W'(i))) begin
                    tx_mem_reg[i] <= wr_data;
                end
            end
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    if (start) begin
                        tx_shift_reg <= tx_flat;
                    end
                end
                SHIFT: begin
                    if (rise_tick) begin
                        rx_shift_reg <= (rx_shift_reg << 1) | TOTAL'(miso);
                    end
                    if (fall_tick) begin
                        tx_shift_reg <= tx_shift_reg << 1;
                        bit_cnt_reg  <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_W'(1);
                    end
                end
                HOLD: begin
                    // Commit on the edge into DONE so the buffer is valid with done.
                    if (hold_done) begin
                        for (int i = 0; i < NUM_DEV; i++) begin
                            rx_mem_reg[i] <= rx_unpacked[i];
                        end
                    end
                end
                default: bit_cnt_reg <= '0;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NUM_DEV) begin
            rd_data = rx_mem_reg[rd_idx];
        end
    end

    assign busy = (state_reg == SHIFT) || (state_reg == HOLD);
    assign done = (state_reg == DONE);
    assign cs_n = ~busy;
    assign sclk = (state_reg == SHIFT) && sclk_phase;
    assign mosi = busy && tx_shift_reg[TOTAL-1];

endmodule
